pipe_stage_ctrl: RTL and testbench
==================================

// Module: pipe_stage_ctrl
// PURPOSE
//  Consumer side of the hazard HOLD handshake: owns the stage-2..5 decoded-instruction
//  registers that feed the hazard unit (Type2/SelA2/SelB2, Type3..5/SelC3..5) and obeys HOLD.
//  On HOLD, freezes fetch and stage 2, injects a bubble into stage 3, drains stages 4-5.
//  Also counts stall cycles and flags a HOLD that never releases (pipeline deadlock watchdog).
// PARAMETERS
//  TYPE_W   7   width of one-hot-per-bit instruction type vector (bit6 = Jump)
//  SELA_W   5   width of source-A register select
//  SELB_W   6   width of source-B select
//  SELC_W   6   width of destination select
//  HOLD_MAX 15  consecutive HOLD cycles after which HOLD_ERR sets (1..2^CNT_W-1)
//  CNT_W    16  width of stall performance counter and hold-run counter
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  reset     in   1       synchronous, active-high; clears all state
//  HOLD      in   1       hazard stall request (combinational from stage registers)
//  FLUSH     in   1       squash instruction entering/in stage 2 (taken jump)
//  TypeD     in   TYPE_W  decoded type of fetched instruction
//  SelAD     in   SELA_W  decoded source A
//  SelBD     in   SELB_W  decoded source B
//  SelCD     in   SELC_W  decoded destination
//  PC_EN     out  1       fetch/PC advance enable
//  Type2/SelA2/SelB2  out  TYPE_W/SELA_W/SELB_W  stage-2 fields to hazard unit
//  Type3/SelA3/SelB3/SelC3  out  TYPE_W/SELA_W/SELB_W/SELC_W  stage-3 (execute) fields
//  Type4/SelC4  out  TYPE_W/SELC_W  stage-4 fields
//  Type5/SelC5  out  TYPE_W/SELC_W  stage-5 (writeback) fields
//  STALL_CNT out  CNT_W   total HOLD cycles since reset, saturating at all-ones
//  HOLD_ERR  out  1       sticky: HOLD held HOLD_MAX consecutive cycles
// BEHAVIOUR
//  Reset: every Type*/Sel* register = 0 (bubble), STALL_CNT=0, run counter=0, HOLD_ERR=0.
//   Reset wins over HOLD/FLUSH; PC_EN = 0 while reset high.
//  Bubble = Type 0 and all Sel 0; hazard unit treats it as no-op.
//  PC_EN = !reset & !HOLD (combinational, no latency). FLUSH does not gate PC_EN.
//  Stage 2 per edge: FLUSH -> bubble; else HOLD -> keep; else load TypeD/SelAD/SelBD/SelCD.
//   SelC of stage 2 held internally, not a port.
//  Stage 3: HOLD or FLUSH -> bubble; else copy of stage 2 (all four fields).
//  Stage 4 <= stage 3 (Type, SelC); stage 5 <= stage 4; unconditional every cycle.
//  Latency: instruction loaded in stage 2 at edge N reaches stage 5 at edge N+3 absent HOLD.
//  HOLD+FLUSH same cycle: stage 2 and stage 3 both bubble; PC_EN=0.
//  HOLD only samples registered state; no combinational path from HOLD to Type2..5.
//  Run counter: HOLD ? min(run+1, HOLD_MAX) : 0. When HOLD high and run == HOLD_MAX-1,
//   HOLD_ERR sets on that edge; it stays 1 until reset. Pipeline keeps obeying HOLD.
//  STALL_CNT increments on every edge where HOLD=1; saturates at 2^CNT_W-1, never wraps.
//  A Jump in stage 2 holding on non-empty stages 3-5 drains them in <=3 cycles;
//   then HOLD drops and the jump advances.
// TESTING
//  1. Reset then feed 4 distinct instrs, HOLD=0 -> each appears at Type2,3,4,5 on
//     successive edges; PC_EN=1 throughout; STALL_CNT=0.
//  2. Instr A in stage 2, HOLD=1 for 2 cycles -> Type2=A held; Type3=0 for 2 cycles;
//     older instrs reach stage 5; PC_EN=0; STALL_CNT=2; A in stage 3 one edge after release.
//  3. FLUSH=1 one cycle, HOLD=0 -> Type2=0 next edge; Type3=0 the following edge;
//     PC_EN stays 1.
//  4. HOLD=1 and FLUSH=1 together -> stage 2 and 3 bubbles, PC_EN=0, STALL_CNT+1.
//  5. HOLD_MAX=15, HOLD stuck high -> HOLD_ERR rises on 15th HOLD edge; stays 1 after
//     HOLD drops; clears only on reset.
//  6. CNT_W=4, HOLD high 20 cycles -> STALL_CNT=15 saturated; reset asserted mid-HOLD
//     -> all stages 0, counters 0 next edge.

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - stage 2..5 decoded-instruction registers obeying hazard HOLD/FLUSH
//
// Purpose: owns the stage-2..5 instruction type/select registers that feed the
//          hazard unit. HOLD freezes fetch and stage 2, injects a bubble into
//          stage 3 and lets stages 4-5 drain. FLUSH squashes stage 2. Also keeps
//          a saturating stall counter and a sticky deadlock watchdog flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   HOLD, FLUSH           stall request, squash of stage 2 (taken jump)
//   TypeD/SelAD/SelBD/SelCD  decoded fields of the fetched instruction
//   PC_EN                 fetch/PC advance enable (combinational)
//   Type2/SelA2/SelB2     stage-2 fields
//   Type3/SelA3/SelB3/SelC3  stage-3 fields
//   Type4/SelC4, Type5/SelC5 stage-4 and stage-5 fields
//   STALL_CNT             saturating count of HOLD cycles since reset
//   HOLD_ERR              sticky: HOLD stayed high HOLD_MAX consecutive cycles

module pipe_stage_ctrl #(
    parameter int TYPE_W   = 7,
    parameter int SELA_W   = 5,
    parameter int SELB_W   = 6,
    parameter int SELC_W   = 6,
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HOLD,
    input  logic              FLUSH,
    input  logic [TYPE_W-1:0] TypeD,
    input  logic [SELA_W-1:0] SelAD,
    input  logic [SELB_W-1:0] SelBD,
    input  logic [SELC_W-1:0] SelCD,
    output logic              PC_EN,
    output logic [TYPE_W-1:0] Type2,
    output logic [SELA_W-1:0] SelA2,
    output logic [SELB_W-1:0] SelB2,
    output logic [TYPE_W-1:0] Type3,
    output logic [SELA_W-1:0] SelA3,
    output logic [SELB_W-1:0] SelB3,
    output logic [SELC_W-1:0] SelC3,
    output logic [TYPE_W-1:0] Type4,
    output logic [SELC_W-1:0] SelC4,
    output logic [TYPE_W-1:0] Type5,
    output logic [SELC_W-1:0] SelC5,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic              HOLD_ERR
);

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    logic [TYPE_W-1:0] type2_q, type2_d, type3_q, type3_d, type4_q, type5_q;
    logic [SELA_W-1:0] sela2_q, sela2_d, sela3_q, sela3_d;
    logic [SELB_W-1:0] selb2_q, selb2_d, selb3_q, selb3_d;
    logic [SELC_W-1:0] selc2_q, selc2_d, selc3_q, selc3_d, selc4_q, selc5_q;
    logic [CNT_W-1:0]  stall_q, stall_d, run_q, run_d;
    logic              err_q, err_d;

    // Fetch advances whenever the hazard unit is not stalling; FLUSH only
    // squashes what is already fetched, so it does not gate the PC.
    assign PC_EN = !reset && !HOLD;

    always_comb begin
        // Stage 2: FLUSH beats HOLD, so a squashed instruction is never held.
        type2_d = type2_q;
        sela2_d = sela2_q;
        selb2_d = selb2_q;
        selc2_d = selc2_q;
        if (FLUSH) begin
            type2_d = '0;
            sela2_d = '0;
            selb2_d = '0;
            selc2_d = '0;
        end else if (!HOLD) begin
            type2_d = TypeD;
            sela2_d = SelAD;
            selb2_d = SelBD;
            selc2_d = SelCD;
        end

        // Stage 3: bubble while stage 2 is held or squashed.
        type3_d = type2_q;
        sela3_d = sela2_q;
        selb3_d = selb2_q;
        selc3_d = selc2_q;
        if (HOLD || FLUSH) begin
            type3_d = '0;
            sela3_d = '0;
            selb3_d = '0;
            selc3_d = '0;
        end

        stall_d = stall_q;
        run_d   = '0;
        err_d   = err_q;
        if (HOLD) begin
            if (stall_q != CNT_SAT) begin
                stall_d = stall_q + 1'b1;
            end
            // Run length saturates at HOLD_MAX; the flag fires on the edge
            // that completes the HOLD_MAX-th consecutive stall cycle.
            run_d = (run_q >= HOLD_MAX_C) ? HOLD_MAX_C : run_q + 1'b1;
            if (run_q == HOLD_MAX_C - 1'b1) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            type2_q <= '0;
            sela2_q <= '0;
            selb2_q <= '0;
            selc2_q <= '0;
            type3_q <= '0;
            sela3_q <= '0;
            selb3_q <= '0;
            selc3_q <= '0;
            type4_q <= '0;
            selc4_q <= '0;
            type5_q <= '0;
            selc5_q <= '0;
            stall_q <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            type2_q <= type2_d;
            sela2_q <= sela2_d;
            selb2_q <= selb2_d;
            selc2_q <= selc2_d;
            type3_q <= type3_d;
            sela3_q <= sela3_d;
            selb3_q <= selb3_d;
            selc3_q <= selc3_d;
            // Stages 4 and 5 always drain, even under HOLD.
            type4_q <= type3_q;
            selc4_q <= selc3_q;
            type5_q <= type4_q;
            selc5_q <= selc4_q;
            stall_q <= stall_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign Type2     = type2_q;
    assign SelA2     = sela2_q;
    assign SelB2     = selb2_q;
    assign Type3     = type3_q;
    assign SelA3     = sela3_q;
    assign SelB3     = selb3_q;
    assign SelC3     = selc3_q;
    assign Type4     = type4_q;
    assign SelC4     = selc4_q;
    assign Type5     = type5_q;
    assign SelC5     = selc5_q;
    assign STALL_CNT = stall_q;
    assign HOLD_ERR  = err_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - scoreboard bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       HOLD = 1'b0;
    logic       FLUSH = 1'b0;
    logic [6:0] TypeD = '0;
    logic [4:0] SelAD = '0;
    logic [5:0] SelBD = '0;
    logic [5:0] SelCD = '0;
    logic       PC_EN;
    logic [6:0] Type2, Type3, Type4, Type5;
    logic [4:0] SelA2, SelA3;
    logic [5:0] SelB2, SelB3, SelC3, SelC4, SelC5;
    logic [3:0] STALL_CNT;
    logic       HOLD_ERR;

    pipe_stage_ctrl #(
        .TYPE_W(7), .SELA_W(5), .SELB_W(6), .SELC_W(6), .HOLD_MAX(15), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .HOLD(HOLD), .FLUSH(FLUSH),
        .TypeD(TypeD), .SelAD(SelAD), .SelBD(SelBD), .SelCD(SelCD),
        .PC_EN(PC_EN),
        .Type2(Type2), .SelA2(SelA2), .SelB2(SelB2),
        .Type3(Type3), .SelA3(SelA3), .SelB3(SelB3), .SelC3(SelC3),
        .Type4(Type4), .SelC4(SelC4), .Type5(Type5), .SelC5(SelC5),
        .STALL_CNT(STALL_CNT), .HOLD_ERR(HOLD_ERR)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] t;
        logic [4:0] a;
        logic [5:0] b;
        logic [5:0] c;
    } instr_t;

    typedef struct packed {
        logic   pc_en;
        instr_t s2;
        instr_t s3;
        instr_t s4;
        instr_t s5;
        logic [3:0] stall;
        logic   err;
    } exp_t;

    exp_t   exp_q[$];
    instr_t pipe[2:5];
    int     m_stall, m_run;
    logic   m_err;
    int     passed = 0;
    int     total = 0;
    int     cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    endtask

    // Monitor: every negedge the DUT presents a full state; compare against
    // the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("PC_EN", int'(PC_EN), int'(e.pc_en));
                chk("Type2", int'(Type2), int'(e.s2.t));
                chk("SelA2", int'(SelA2), int'(e.s2.a));
                chk("SelB2", int'(SelB2), int'(e.s2.b));
                chk("Type3", int'(Type3), int'(e.s3.t));
                chk("SelA3", int'(SelA3), int'(e.s3.a));
                chk("SelB3", int'(SelB3), int'(e.s3.b));
                chk("SelC3", int'(SelC3), int'(e.s3.c));
                chk("Type4", int'(Type4), int'(e.s4.t));
                chk("SelC4", int'(SelC4), int'(e.s4.c));
                chk("Type5", int'(Type5), int'(e.s5.t));
                chk("SelC5", int'(SelC5), int'(e.s5.c));
                chk("STALL_CNT", int'(STALL_CNT), int'(e.stall));
                chk("HOLD_ERR", int'(HOLD_ERR), int'(e.err));
            end
        end
    end

    function automatic instr_t mk(input int n);
        instr_t r;
        r.t = 7'(n * 3 + 1);
        r.a = 5'(n + 1);
        r.b = 6'(n + 17);
        r.c = 6'(n + 33);
        return r;
    endfunction

    // Drive one cycle: push the expectation for the current state, then let
    // the clock edge happen and advance the reference pipeline.
    task automatic step(input logic r, input logic h, input logic f, input instr_t d);
        exp_t   e;
        instr_t bub;
        bub = '0;
        reset = r; HOLD = h; FLUSH = f;
        TypeD = d.t; SelAD = d.a; SelBD = d.b; SelCD = d.c;
        e.pc_en = !r && !h;
        e.s2 = pipe[2];
        e.s3 = pipe[3];
        e.s4 = '{t: pipe[4].t, a: 5'd0, b: 6'd0, c: pipe[4].c};
        e.s5 = '{t: pipe[5].t, a: 5'd0, b: 6'd0, c: pipe[5].c};
        e.stall = 4'(m_stall);
        e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int i = 2; i <= 5; i++) pipe[i] = bub;
            m_stall = 0; m_run = 0; m_err = 1'b0;
        end else begin
            pipe[5] = pipe[4];
            pipe[4] = pipe[3];
            pipe[3] = (h || f) ? bub : pipe[2];
            if (f) pipe[2] = bub;
            else if (!h) pipe[2] = d;
            if (h) begin
                if (m_run == 14) m_err = 1'b1;
                m_run = (m_run + 1 > 15) ? 15 : m_run + 1;
                if (m_stall < 15) m_stall++;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    initial begin
        instr_t z;
        z = '0;
        for (int i = 2; i <= 5; i++) pipe[i] = '0;
        m_stall = 0; m_run = 0; m_err = 1'b0;
        @(posedge clk); #1;

        // Reset
        step(1, 0, 0, mk(9));
        step(1, 0, 0, mk(9));

        // 1. straight-line flow
        for (int i = 0; i < 4; i++) step(0, 0, 0, mk(i));
        chk("t1 Type5=A", int'(Type5), 1);
        chk("t1 Type2=D", int'(Type2), 10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, z);

        // 2. hold two cycles with A (type 13) in stage 2
        step(0, 0, 0, mk(4));
        step(0, 1, 0, mk(5));
        step(0, 1, 0, mk(5));
        chk("t2 Type2 held", int'(Type2), 13);
        chk("t2 Type3 bubble", int'(Type3), 0);
        chk("t2 STALL_CNT", int'(STALL_CNT), 2);
        step(0, 0, 0, mk(5));
        chk("t2 Type3 after release", int'(Type3), 13);

        // 3. flush alone
        step(0, 0, 0, mk(6));
        step(0, 0, 1, mk(7));
        chk("t3 Type2 flushed", int'(Type2), 0);
        step(0, 0, 0, mk(8));
        chk("t3 Type3 bubble", int'(Type3), 0);

        // 4. hold + flush together
        step(0, 1, 1, mk(10));
        chk("t4 Type2", int'(Type2), 0);
        chk("t4 Type3", int'(Type3), 0);
        chk("t4 STALL_CNT", int'(STALL_CNT), 3);

        // 5. watchdog
        step(1, 0, 0, z);
        step(0, 0, 0, mk(11));
        for (int i = 0; i < 14; i++) step(0, 1, 0, mk(12));
        chk("t5 HOLD_ERR after 14", int'(HOLD_ERR), 0);
        step(0, 1, 0, mk(12));
        chk("t5 HOLD_ERR after 15", int'(HOLD_ERR), 1);
        step(0, 0, 0, mk(12));
        step(0, 0, 0, z);
        chk("t5 HOLD_ERR sticky", int'(HOLD_ERR), 1);

        // 6. stall counter saturation, reset mid-hold
        step(1, 0, 0, z);
        step(0, 0, 0, mk(13));
        for (int i = 0; i < 20; i++) step(0, 1, 0, mk(14));
        chk("t6 STALL_CNT sat", int'(STALL_CNT), 15);
        step(1, 1, 0, mk(14));
        chk("t6 STALL_CNT reset", int'(STALL_CNT), 0);
        chk("t6 Type2 reset", int'(Type2), 0);
        chk("t6 HOLD_ERR reset", int'(HOLD_ERR), 0);
        step(0, 0, 0, z);
        step(0, 0, 0, z);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
